plot_sink: RTL and testbench

Framebuffer-side terminator of the sprite plot stream (`x`, `y`, `color`, `writeEn`). Drawers emit one pixel per cycle with no backpressure. This block:
- buffers pixels in a small FIFO,
- converts (x, y) to a linear framebuffer address,
- drives a valid/ready write port into video memory,
- performs full-screen clears on request between drawing passes.

---
 rtl/plot_sink_pkg.sv | 31 +++
 rtl/plot_fifo.sv | 85 ++++++++
 rtl/plot_sink.sv | 192 +++++++++++++++++++
 tb/tb_plot_sink.sv | 369 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/plot_sink_pkg.sv
// ============================================================================
// Module      : plot_sink_pkg
// Description : Shared types and defaults for the plot_sink framebuffer
//               terminator (screen geometry, color width, pixel record,
//               controller state encoding).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package plot_sink_pkg;

    localparam int DEF_SCREEN_W = 320;
    localparam int DEF_SCREEN_H = 240;
    localparam int DEF_ADDR_W   = 17;
    localparam int COLOR_W      = 3;

    // One queued framebuffer write at the default geometry.
    typedef struct packed {
        logic [DEF_ADDR_W-1:0] addr;
        logic [COLOR_W-1:0]    color;
    } fb_pixel_t;

    // RUN drains the pixel FIFO, CLEAR sweeps the whole screen.
    typedef enum logic [0:0] {
        ST_RUN   = 1'b0,
        ST_CLEAR = 1'b1
    } state_t;

endpackage

`default_nettype wire

// File: rtl/plot_fifo.sv
// ============================================================================
// Module      : plot_fifo
// Description : Synchronous FIFO, power-of-two depth, separate read/write
//               pointers plus an occupancy count. full/empty are registered
//               and reflect occupancy after the current edge. A push while
//               full is ignored even when a pop happens in the same cycle.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module plot_fifo #(
    parameter int WIDTH = 20,
    parameter int DEPTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_data,
    output logic             o_full,
    output logic             o_empty
);

    localparam int c_PTR_W = $clog2(DEPTH);
    localparam int c_CNT_W = c_PTR_W + 1;

    logic [WIDTH-1:0]   r_mem [DEPTH];
    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic [c_CNT_W-1:0] r_count;
    logic [c_CNT_W-1:0] w_count_d;
    logic               r_full;
    logic               r_empty;
    logic               w_do_push;
    logic               w_do_pop;

    assign w_do_push = i_push & ~r_full;
    assign w_do_pop  = i_pop & ~r_empty;

    // Next occupancy: a simultaneous push and pop leaves the count unchanged.
    always_comb begin
        w_count_d = r_count;
        if (w_do_push && !w_do_pop) begin
            w_count_d = r_count + c_CNT_W'(1);
        end else if (!w_do_push && w_do_pop) begin
            w_count_d = r_count - c_CNT_W'(1);
        end
    end

    // Pointers, count and status flags.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_full   <= 1'b0;
            r_empty  <= 1'b1;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
            end
            r_count <= w_count_d;
            r_full  <= (w_count_d == c_CNT_W'(DEPTH));
            r_empty <= (w_count_d == '0);
        end
    end

    // Storage array; contents need no reset since the pointers gate reads.
    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    assign o_data  = r_mem[r_rd_ptr];
    assign o_full  = r_full;
    assign o_empty = r_empty;

endmodule

`default_nettype wire

// File: rtl/plot_sink.sv
// ============================================================================
// Module      : plot_sink
// Description : Terminates the sprite plot stream. Pixels are converted to a
//               linear address (y*SCREEN_W + x) at ingress, buffered in a
//               FIFO and written to video memory through a single valid/ready
//               output register. A clear pulse schedules a full-screen fill
//               that starts once previously queued pixels have drained.
//               Optional: define PLOT_SINK_CLIP_EN to drop off-screen pixels.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module plot_sink
    import plot_sink_pkg::*;
#(
    parameter int SCREEN_W   = DEF_SCREEN_W,
    parameter int SCREEN_H   = DEF_SCREEN_H,
    parameter int FIFO_DEPTH = 16,
    parameter int ADDR_W     = DEF_ADDR_W
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               plot,
    input  logic [9:0]         x_pix,
    input  logic [9:0]         y_pix,
    input  logic [COLOR_W-1:0] color,
    input  logic               clear,
    input  logic [COLOR_W-1:0] clear_color,
    input  logic               fb_ready,
    output logic               fb_we,
    output logic [ADDR_W-1:0]  fb_addr,
    output logic [COLOR_W-1:0] fb_data,
    output logic               full,
    output logic               idle,
    output logic [7:0]         drop_count
);

    localparam int                c_ENTRY_W   = ADDR_W + COLOR_W;
    localparam logic [ADDR_W-1:0] c_LAST_ADDR = ADDR_W'(SCREEN_W * SCREEN_H - 1);

    state_t               r_state,     w_state_d;
    logic                 r_pending,   w_pending_d;
    logic [ADDR_W-1:0]    r_sweep,     w_sweep_d;
    logic [COLOR_W-1:0]   r_clr_color, w_clr_color_d;
    logic                 r_fb_we,     w_fb_we_d;
    logic [ADDR_W-1:0]    r_fb_addr,   w_fb_addr_d;
    logic [COLOR_W-1:0]   r_fb_data,   w_fb_data_d;
    logic [7:0]           r_drop;

    logic [ADDR_W-1:0]    w_addr;
    logic                 w_clip;
    logic                 w_push;
    logic                 w_pop;
    logic                 w_drop;
    logic                 w_full;
    logic                 w_empty;
    logic [c_ENTRY_W-1:0] w_head;
    logic                 w_stage_free;
    logic                 w_accept;

    // Full-width product, then truncated to the framebuffer address width.
    assign w_addr = ADDR_W'(32'(y_pix) * 32'(SCREEN_W) + 32'(x_pix));

`ifdef PLOT_SINK_CLIP_EN
    assign w_clip = (32'(x_pix) >= 32'(SCREEN_W)) || (32'(y_pix) >= 32'(SCREEN_H));
`else
    assign w_clip = 1'b0;
`endif

    assign w_push       = plot & ~w_full & ~w_clip;
    assign w_drop       = plot & (w_full | w_clip);
    assign w_stage_free = ~r_fb_we | fb_ready;
    assign w_accept     = r_fb_we & fb_ready;

    plot_fifo #(
        .WIDTH (c_ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .i_push  (w_push),
        .i_data  ({w_addr, color}),
        .i_pop   (w_pop),
        .o_data  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    // Controller: chooses what feeds the output register each cycle.
    always_comb begin
        w_state_d     = r_state;
        w_pending_d   = r_pending;
        w_sweep_d     = r_sweep;
        w_clr_color_d = r_clr_color;
        w_fb_we_d     = r_fb_we;
        w_fb_addr_d   = r_fb_addr;
        w_fb_data_d   = r_fb_data;
        w_pop         = 1'b0;

        // A clear request is only latched when none is outstanding.
        if (clear && !r_pending && (r_state == ST_RUN)) begin
            w_pending_d = 1'b1;
        end

        case (r_state)
            ST_RUN: begin
                if (w_stage_free) begin
                    if (r_pending && w_empty) begin
                        // Enter the sweep with address 0 already presented.
                        w_state_d     = ST_CLEAR;
                        w_clr_color_d = clear_color;
                        w_fb_we_d     = 1'b1;
                        w_fb_addr_d   = '0;
                        w_fb_data_d   = clear_color;
                        w_sweep_d     = ADDR_W'(1);
                    end else if (!w_empty) begin
                        w_pop       = 1'b1;
                        w_fb_we_d   = 1'b1;
                        w_fb_addr_d = w_head[c_ENTRY_W-1:COLOR_W];
                        w_fb_data_d = w_head[COLOR_W-1:0];
                    end else begin
                        w_fb_we_d = 1'b0;
                    end
                end
            end
            ST_CLEAR: begin
                if (w_accept) begin
                    if (r_fb_addr == c_LAST_ADDR) begin
                        // Sweep done; pixels queued meanwhile follow directly.
                        w_state_d   = ST_RUN;
                        w_pending_d = 1'b0;
                        if (!w_empty) begin
                            w_pop       = 1'b1;
                            w_fb_we_d   = 1'b1;
                            w_fb_addr_d = w_head[c_ENTRY_W-1:COLOR_W];
                            w_fb_data_d = w_head[COLOR_W-1:0];
                        end else begin
                            w_fb_we_d = 1'b0;
                        end
                    end else begin
                        w_fb_addr_d = r_sweep;
                        w_fb_data_d = r_clr_color;
                        w_sweep_d   = r_sweep + ADDR_W'(1);
                    end
                end
            end
            default: begin
                w_state_d = ST_RUN;
            end
        endcase
    end

    // Controller and output-stage registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= ST_RUN;
            r_pending   <= 1'b0;
            r_sweep     <= '0;
            r_clr_color <= '0;
            r_fb_we     <= 1'b0;
            r_fb_addr   <= '0;
            r_fb_data   <= '0;
        end else begin
            r_state     <= w_state_d;
            r_pending   <= w_pending_d;
            r_sweep     <= w_sweep_d;
            r_clr_color <= w_clr_color_d;
            r_fb_we     <= w_fb_we_d;
            r_fb_addr   <= w_fb_addr_d;
            r_fb_data   <= w_fb_data_d;
        end
    end

    // Saturating count of pixels lost to overflow or clipping.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_drop <= '0;
        end else if (w_drop && (r_drop != 8'hFF)) begin
            r_drop <= r_drop + 8'd1;
        end
    end

    assign fb_we      = r_fb_we;
    assign fb_addr    = r_fb_addr;
    assign fb_data    = r_fb_data;
    assign full       = w_full;
    assign idle       = w_empty & ~r_pending & (r_state == ST_RUN) & ~r_fb_we;
    assign drop_count = r_drop;

endmodule

`default_nettype wire

// File: tb/tb_plot_sink.sv
// ============================================================================
// Module      : tb_plot_sink
// Description : Self-checking bench for plot_sink. Writes accepted by the
//               framebuffer are logged and compared against an ordered list
//               of expected writes computed from screen geometry.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_plot_sink;

    localparam int W    = 320;
    localparam int H    = 240;
    localparam int AW   = 17;
    localparam int NPIX = W * H;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          plot = 1'b0;
    logic [9:0]    x_pix = '0;
    logic [9:0]    y_pix = '0;
    logic [2:0]    color = '0;
    logic          clear = 1'b0;
    logic [2:0]    clear_color = '0;
    logic          fb_ready = 1'b0;
    logic          fb_we;
    logic [AW-1:0] fb_addr;
    logic [2:0]    fb_data;
    logic          full;
    logic          idle;
    logic [7:0]    drop_count;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;

    typedef struct { int addr; int data; int cyc; } wr_t;
    typedef struct { int x; int y; int c; } pix_t;

    wr_t obs[$];

    plot_sink #(
        .SCREEN_W   (W),
        .SCREEN_H   (H),
        .FIFO_DEPTH (16),
        .ADDR_W     (AW)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .plot        (plot),
        .x_pix       (x_pix),
        .y_pix       (y_pix),
        .color       (color),
        .clear       (clear),
        .clear_color (clear_color),
        .fb_ready    (fb_ready),
        .fb_we       (fb_we),
        .fb_addr     (fb_addr),
        .fb_data     (fb_data),
        .full        (full),
        .idle        (idle),
        .drop_count  (drop_count)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Log every write the framebuffer accepts at the coming edge.
    always @(negedge clk) begin : mon
        wr_t w;
        if (fb_we === 1'b1 && fb_ready === 1'b1) begin
            w.addr = int'(fb_addr);
            w.data = int'(fb_data);
            w.cyc  = cyc;
            obs.push_back(w);
        end
    end

    initial begin
        #20000000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        plot  = 1'b0;
        clear = 1'b0;
        step();
        step();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; plot = 1'b1; x_pix = 10'd7; y_pix = 10'd3; color = 3'd5;
        clear = 1'b0; fb_ready = 1'b1;
        step();
        step();
        n_checks++; if (fb_we !== 1'b0) $display("FAIL reset_fb_we: got %0b expected 0", fb_we); else n_pass++;
        n_checks++; if (fb_addr !== '0) $display("FAIL reset_fb_addr: got %0d expected 0", fb_addr); else n_pass++;
        n_checks++; if (fb_data !== '0) $display("FAIL reset_fb_data: got %0d expected 0", fb_data); else n_pass++;
        n_checks++; if (full !== 1'b0) $display("FAIL reset_full: got %0b expected 0", full); else n_pass++;
        n_checks++; if (idle !== 1'b1) $display("FAIL reset_idle: got %0b expected 1", idle); else n_pass++;
        n_checks++; if (drop_count !== 8'd0) $display("FAIL reset_drop: got %0d expected 0", drop_count); else n_pass++;
        plot = 1'b0;
        reset = 1'b0;
    endtask

    task automatic test_basic_write();
        do_reset();
        obs.delete();
        fb_ready = 1'b1;
        plot = 1'b1; x_pix = 10'd5; y_pix = 10'd2; color = 3'd3;
        step();
        plot = 1'b0;
        n_checks++; if (fb_we !== 1'b0) $display("FAIL basic_lat_n1: fb_we got %0b expected 0", fb_we); else n_pass++;
        step();
        n_checks++; if (fb_we !== 1'b1) $display("FAIL basic_lat_n2: fb_we got %0b expected 1", fb_we); else n_pass++;
        n_checks++; if (fb_addr !== AW'(2 * W + 5)) $display("FAIL basic_addr: got %0d expected %0d", fb_addr, 2 * W + 5); else n_pass++;
        n_checks++; if (fb_data !== 3'd3) $display("FAIL basic_data: got %0d expected 3", fb_data); else n_pass++;
        n_checks++; if (idle !== 1'b0) $display("FAIL basic_busy: idle got %0b expected 0", idle); else n_pass++;
        step();
        step();
        n_checks++; if (idle !== 1'b1) $display("FAIL basic_idle: got %0b expected 1", idle); else n_pass++;
        n_checks++; if (obs.size() != 1) $display("FAIL basic_count: got %0d writes expected 1", obs.size()); else n_pass++;
    endtask

    task automatic test_backpressure();
        pix_t p[20];
        int   t;
        logic [AW+3:0] exp_stage;
        do_reset();
        obs.delete();
        fb_ready = 1'b0;
        for (int k = 0; k < 20; k++) begin
            p[k].x = int'($urandom_range(0, W - 1));
            p[k].y = int'($urandom_range(0, H - 1));
            p[k].c = int'($urandom_range(0, 7));
        end
        exp_stage = {1'b1, AW'(p[0].y * W + p[0].x), 3'(p[0].c)};
        for (int k = 0; k < 20; k++) begin
            plot = 1'b1; x_pix = 10'(p[k].x); y_pix = 10'(p[k].y); color = 3'(p[k].c);
            step();
            n_checks++;
            if (full !== (k + 1 >= 17)) $display("FAIL bp_full_%0d: got %0b expected %0b", k, full, (k + 1 >= 17));
            else n_pass++;
            if (k >= 1) begin
                n_checks++;
                if ({fb_we, fb_addr, fb_data} !== exp_stage)
                    $display("FAIL bp_stable_%0d: got we=%0b addr=%0d data=%0d expected addr=%0d data=%0d",
                             k, fb_we, fb_addr, fb_data, p[0].y * W + p[0].x, p[0].c);
                else n_pass++;
            end
        end
        plot = 1'b0;
        for (int k = 0; k < 4; k++) begin
            step();
            n_checks++;
            if ({fb_we, fb_addr, fb_data} !== exp_stage)
                $display("FAIL bp_hold_%0d: got we=%0b addr=%0d data=%0d", k, fb_we, fb_addr, fb_data);
            else n_pass++;
        end
        n_checks++; if (drop_count !== 8'd3) $display("FAIL bp_drop: got %0d expected 3", drop_count); else n_pass++;
        fb_ready = 1'b1;
        t = 0;
        while (obs.size() < 17 && t < 100) begin step(); t++; end
        for (int k = 0; k < 10; k++) step();
        n_checks++; if (obs.size() != 17) $display("FAIL bp_count: got %0d writes expected 17", obs.size()); else n_pass++;
        for (int k = 0; k < 17 && k < obs.size(); k++) begin
            n_checks++;
            if (obs[k].addr != p[k].y * W + p[k].x || obs[k].data != p[k].c)
                $display("FAIL bp_order_%0d: got addr=%0d data=%0d expected addr=%0d data=%0d",
                         k, obs[k].addr, obs[k].data, p[k].y * W + p[k].x, p[k].c);
            else n_pass++;
        end
        n_checks++; if (idle !== 1'b1 || full !== 1'b0) $display("FAIL bp_drained: idle=%0b full=%0b expected 1,0", idle, full); else n_pass++;
    endtask

    task automatic test_random_stream();
        pix_t sent[$];
        pix_t q;
        int   t;
        int   errs;
        int   first_bad;
        do_reset();
        obs.delete();
        for (int c = 0; c < 600; c++) begin
            fb_ready = ($urandom_range(0, 3) != 0);
            if ((sent.size() - obs.size() < 8) && ($urandom_range(0, 1) == 1)) begin
                q.x = int'($urandom_range(0, W - 1));
                q.y = int'($urandom_range(0, H - 1));
                q.c = int'($urandom_range(0, 7));
                plot = 1'b1; x_pix = 10'(q.x); y_pix = 10'(q.y); color = 3'(q.c);
                sent.push_back(q);
            end else begin
                plot = 1'b0;
            end
            step();
        end
        plot = 1'b0;
        fb_ready = 1'b1;
        t = 0;
        while (obs.size() < sent.size() && t < 200) begin step(); t++; end
        for (int k = 0; k < 5; k++) step();
        n_checks++;
        if (obs.size() != sent.size()) $display("FAIL rand_count: got %0d writes expected %0d", obs.size(), sent.size());
        else n_pass++;
        errs = 0;
        first_bad = -1;
        for (int k = 0; k < sent.size() && k < obs.size(); k++) begin
            if (obs[k].addr != sent[k].y * W + sent[k].x || obs[k].data != sent[k].c) begin
                errs++;
                if (first_bad < 0) first_bad = k;
            end
        end
        n_checks++;
        if (errs != 0) $display("FAIL rand_content: got %0d bad writes (first at %0d) expected 0", errs, first_bad);
        else n_pass++;
        n_checks++; if (drop_count !== 8'd0) $display("FAIL rand_drop: got %0d expected 0", drop_count); else n_pass++;
    endtask

    task automatic test_clear_ordering();
        pix_t q[4];
        pix_t mid;
        int   t;
        int   errs;
        int   first_bad;
        do_reset();
        obs.delete();
        fb_ready = 1'b0;
        clear_color = 3'd1;
        for (int k = 0; k < 4; k++) begin
            q[k].x = int'($urandom_range(0, W - 1));
            q[k].y = int'($urandom_range(0, H - 1));
            q[k].c = int'($urandom_range(2, 7));
            plot = 1'b1; x_pix = 10'(q[k].x); y_pix = 10'(q[k].y); color = 3'(q[k].c);
            step();
        end
        plot = 1'b0;
        clear = 1'b1;
        step();
        clear = 1'b0;
        fb_ready = 1'b1;
        t = 0;
        while (obs.size() < 204 && t < 1000) begin step(); t++; end
        mid.x = 10; mid.y = 20; mid.c = 6;
        plot = 1'b1; x_pix = 10'(mid.x); y_pix = 10'(mid.y); color = 3'(mid.c);
        step();
        plot = 1'b0;
        t = 0;
        while (obs.size() < 1004 && t < 1000) begin step(); t++; end
        // A second request mid-sweep, with a new color that must not take effect.
        clear = 1'b1;
        clear_color = 3'd4;
        step();
        clear = 1'b0;
        t = 0;
        while (obs.size() < 4 + NPIX + 1 && t < 80000) begin step(); t++; end
        for (int k = 0; k < 300; k++) step();
        n_checks++;
        if (obs.size() != 4 + NPIX + 1) $display("FAIL clr_count: got %0d writes expected %0d", obs.size(), 4 + NPIX + 1);
        else n_pass++;
        if (obs.size() >= 4 + NPIX + 1) begin
            for (int k = 0; k < 4; k++) begin
                n_checks++;
                if (obs[k].addr != q[k].y * W + q[k].x || obs[k].data != q[k].c)
                    $display("FAIL clr_pre_%0d: got addr=%0d data=%0d expected addr=%0d data=%0d",
                             k, obs[k].addr, obs[k].data, q[k].y * W + q[k].x, q[k].c);
                else n_pass++;
            end
            errs = 0;
            first_bad = -1;
            for (int k = 0; k < NPIX; k++) begin
                if (obs[4 + k].addr != k || obs[4 + k].data != 1) begin
                    errs++;
                    if (first_bad < 0) first_bad = k;
                end
            end
            n_checks++;
            if (errs != 0) $display("FAIL clr_sweep: got %0d bad writes (first at %0d) expected 0", errs, first_bad);
            else n_pass++;
            n_checks++;
            if (obs[4 + NPIX - 1].cyc - obs[4].cyc != NPIX - 1)
                $display("FAIL clr_duration: got %0d cycles expected %0d", obs[4 + NPIX - 1].cyc - obs[4].cyc + 1, NPIX);
            else n_pass++;
            n_checks++;
            if (obs[4 + NPIX].addr != mid.y * W + mid.x || obs[4 + NPIX].data != mid.c)
                $display("FAIL clr_mid_pixel: got addr=%0d data=%0d expected addr=%0d data=%0d",
                         obs[4 + NPIX].addr, obs[4 + NPIX].data, mid.y * W + mid.x, mid.c);
            else n_pass++;
        end
        n_checks++; if (idle !== 1'b1) $display("FAIL clr_idle: got %0b expected 1", idle); else n_pass++;
    endtask

    task automatic test_clip();
        do_reset();
        obs.delete();
        fb_ready = 1'b1;
        plot = 1'b1; x_pix = 10'd320; y_pix = 10'd0; color = 3'd5;
        step();
        plot = 1'b0;
        for (int k = 0; k < 8; k++) step();
`ifdef PLOT_SINK_CLIP_EN
        n_checks++; if (obs.size() != 0) $display("FAIL clip_nowrite: got %0d writes expected 0", obs.size()); else n_pass++;
        n_checks++; if (drop_count !== 8'd1) $display("FAIL clip_drop: got %0d expected 1", drop_count); else n_pass++;
`else
        n_checks++;
        if (obs.size() != 1) $display("FAIL clip_write: got %0d writes expected 1", obs.size());
        else if (obs[0].addr != 320 || obs[0].data != 5)
            $display("FAIL clip_write: got addr=%0d data=%0d expected addr=320 data=5", obs[0].addr, obs[0].data);
        else n_pass++;
        n_checks++; if (drop_count !== 8'd0) $display("FAIL clip_drop: got %0d expected 0", drop_count); else n_pass++;
`endif
    endtask

    task automatic test_reset_mid_clear();
        int t;
        do_reset();
        obs.delete();
        fb_ready = 1'b1;
        clear_color = 3'd2;
        clear = 1'b1;
        step();
        clear = 1'b0;
        t = 0;
        while (!(fb_we === 1'b1 && fb_addr === AW'(1000)) && t < 3000) begin step(); t++; end
        n_checks++; if (t >= 3000) $display("FAIL rmc_reach: sweep address 1000 not seen, got %0d", fb_addr); else n_pass++;
        reset = 1'b1;
        step();
        n_checks++; if (fb_we !== 1'b0) $display("FAIL rmc_we: got %0b expected 0", fb_we); else n_pass++;
        n_checks++; if (idle !== 1'b1) $display("FAIL rmc_idle: got %0b expected 1", idle); else n_pass++;
        reset = 1'b0;
        obs.delete();
        clear_color = 3'd3;
        clear = 1'b1;
        step();
        clear = 1'b0;
        t = 0;
        while (obs.size() < 3 && t < 20) begin step(); t++; end
        n_checks++;
        if (obs.size() < 3) $display("FAIL rmc_restart: got %0d writes expected at least 3", obs.size());
        else if (obs[0].addr != 0 || obs[1].addr != 1 || obs[2].addr != 2 || obs[0].data != 3)
            $display("FAIL rmc_restart: got addr=%0d,%0d,%0d data=%0d expected addr=0,1,2 data=3",
                     obs[0].addr, obs[1].addr, obs[2].addr, obs[0].data);
        else n_pass++;
        do_reset();
    endtask

    initial begin
        test_reset();
        test_basic_write();
        test_backpressure();
        test_random_stream();
        test_clip();
        test_reset_mid_clear();
        test_clear_ordering();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
